muldiv_iter_unit: RTL
=====================

Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; successor to the fixed 32-bit mul/div pair.
- One block handles mult, multu, div and divu at any even WIDTH, behind a start/ready handshake with annul support.
- The result is packed for the HI/LO write path as {hi, lo}. For multiply, hi is the upper half of the product; for divide, hi is the remainder and lo the quotient.
- A divide-by-zero flag is provided for the exception path.

Parameters:
- WIDTH, 32, operand width in bits; even, >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start_i  input  1  request pulse; sampled only when busy_o=0.
- op_i  input  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start_i.
- opa_i  input  WIDTH  multiplicand or dividend.
- opb_i  input  WIDTH  multiplier or divisor.
- annul_i  input  1  abort the in-flight operation.
- busy_o  output  1  high while iterating.
- ready_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  2*WIDTH  {hi, lo}; held until the next accepted start.
- div_by_zero_o  output  1  set with ready_o for div/divu by 0; held with result_o.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, busy_o=0, ready_o=0, result_o=0, div_by_zero_o=0. Reset mid-operation discards the operation and produces no ready pulse.
- States and transitions:
  - IDLE: start_i=1 and annul_i=0 on edge E0 -> CALC with counter=0. For a divide with opb_i=0, go straight to DONE instead.
  - CALC: one iteration per edge. Counter reaching WIDTH-1 at an edge -> DONE.
  - DONE: single cycle. Returns to IDLE, or accepts a new start exactly as IDLE does.
- Latency: ready_o is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after start is asserted. A divide by zero raises ready_o in the cycle after E0.
- busy_o=1 only in CALC. start_i is ignored while busy_o=1.
- Operand capture at E0:
  - Signed ops (mult, div) convert operands to WIDTH-bit magnitudes.
  - The quotient/product sign (signa^signb) and remainder sign (signa) are latched.
  - Unsigned ops use operands as-is.
- Multiply: radix-2 shift-add over WIDTH iterations on a 2*WIDTH accumulator.
- Divide: restoring radix-2, one quotient bit per iteration, on a WIDTH+1 bit partial remainder.
- Sign correction: applied in the same edge that enters DONE, via two's-complement negate of the magnitude.
  - Signed mult negates the full 2*WIDTH product.
  - div negates the quotient and the remainder independently.
  - Remainder sign equals dividend sign.
- Overflow: div of the most-negative value by -1 gives quotient=most-negative (wraps) and remainder=0. No flag is raised.
- Divide by zero: result_o={opa_i, all-ones}, div_by_zero_o=1, for both signed and unsigned.
- Annul: annul_i=1 in CALC or DONE -> IDLE at the next edge.
  - ready_o stays 0 (a DONE-cycle annul does not suppress a pulse already visible).
  - result_o and div_by_zero_o keep their previous values.
  - annul_i with start_i in the same cycle: annul wins and nothing is accepted.
- ready_o is registered, never combinational from inputs.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - mult/multu use a single-cycle combinational WIDTH x WIDTH multiplier.
  - Both go IDLE -> DONE at E0, so ready_o rises in the cycle after E0 and busy_o never rises.
  - Divide is unchanged.
- Undefined: the iterative shift-add multiplier above, WIDTH-cycle latency, no hardware multiplier inferred.

Test Plan (WIDTH=32):
- divu opa=100 opb=7 -> ready_o pulses exactly 33 cycles after start; result_o={32'd2, 32'd14}; div_by_zero_o=0.
- div opa=-7 (0xFFFFFFF9) opb=2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3). Also div 0x80000000 / 0xFFFFFFFF -> {0x00000000, 0x80000000}.
- divu opa=5 opb=0 -> ready_o in the cycle after start, busy_o never high; result_o={0x00000005, 0xFFFFFFFF}; div_by_zero_o=1.
- mult -3 * 5 -> 64'hFFFFFFFF_FFFFFFF1. multu 0xFFFFFFFF * 0xFFFFFFFF -> 64'hFFFFFFFE_00000001. Check latency in both macro builds: 33 cycles without the macro, 1 with it.
- div started, annul_i pulsed on CALC cycle 10 -> busy_o low next cycle, no ready_o, result_o unchanged. A start issued 1 cycle later completes normally. start_i pulsed while busy_o=1 is ignored.
- rst asserted asynchronously mid-CALC -> all outputs 0 immediately. After rst releases, a multu 3*4 gives {0, 12}.

Source files
------------

// File: rtl/muldiv_iter_unit.sv
// Iterative signed/unsigned multiply and divide unit, result packed as {hi, lo}.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module muldiv_iter_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 ready_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_ready;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_dbz;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_divisor;

  logic                 w_op_div;
  logic                 w_op_signed;
  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_dbz_req;
  logic                 w_fast_req;
  logic [2*WIDTH-1:0]   w_fast_prod;
  logic                 w_accept;
  logic                 w_last;

  assign w_op_div    = op_i[1];
  assign w_op_signed = ~op_i[0];
  assign w_sign_a    = w_op_signed & opa_i[WIDTH-1];
  assign w_sign_b    = w_op_signed & opb_i[WIDTH-1];
  assign w_mag_a     = w_sign_a ? (-opa_i) : opa_i;
  assign w_mag_b     = w_sign_b ? (-opb_i) : opb_i;
  assign w_dbz_req   = w_op_div & (opb_i == '0);
  assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  // Low 2*WIDTH bits of the extended product are correct for both signednesses.
  assign w_ext_a     = {{WIDTH{w_sign_a}}, opa_i};
  assign w_ext_b     = {{WIDTH{w_sign_b}}, opb_i};
  assign w_fast_prod = w_ext_a * w_ext_b;
  assign w_fast_req  = ~w_op_div;
`else
  assign w_fast_prod = '0;
  assign w_fast_req  = 1'b0;
`endif

  // Shift-add step: conditionally add multiplicand to the high half, then shift right.
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring division step on a WIDTH+1 bit shifted partial remainder.
  logic [WIDTH:0]       w_shift;
  logic                 w_ge;
  logic [WIDTH:0]       w_diff;
  logic [WIDTH-1:0]     w_rem_next;
  logic [WIDTH-1:0]     w_quo_next;
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge       = (w_shift >= {1'b0, r_divisor});
  assign w_diff     = w_shift - {1'b0, r_divisor};
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_ge};

  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_quo_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic [2*WIDTH-1:0]   w_final;
  assign w_prod_fix = r_neg_q ? (-w_acc_next) : w_acc_next;
  assign w_quo_fix  = r_neg_q ? (-w_quo_next) : w_quo_next;
  assign w_rem_fix  = r_neg_r ? (-w_rem_next) : w_rem_next;
  assign w_final    = r_is_div ? {w_rem_fix, w_quo_fix} : w_prod_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i && !annul_i) begin
          w_accept     = 1'b1;
          w_state_next = (w_dbz_req || w_fast_req) ? S_DONE : S_CALC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (annul_i) begin
          w_state_next = S_IDLE;
        end else if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_result  <= '0;
      r_dbz     <= 1'b0;
      r_is_div  <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else begin
      r_ready <= 1'b0;
      if (w_accept) begin
        r_cnt     <= '0;
        r_is_div  <= w_op_div;
        r_neg_q   <= w_sign_a ^ w_sign_b;
        r_neg_r   <= w_sign_a;
        r_acc     <= {{WIDTH{1'b0}}, w_mag_b};
        r_mcand   <= w_mag_a;
        r_rem     <= '0;
        r_quo     <= w_mag_a;
        r_divisor <= w_mag_b;
        if (w_dbz_req) begin
          r_result <= {opa_i, {WIDTH{1'b1}}};
          r_dbz    <= 1'b1;
          r_ready  <= 1'b1;
        end else if (w_fast_req) begin
          r_result <= w_fast_prod;
          r_dbz    <= 1'b0;
          r_ready  <= 1'b1;
        end
      end else if (r_state == S_CALC && !annul_i) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_next;
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
        if (w_last) begin
          r_result <= w_final;
          r_dbz    <= 1'b0;
          r_ready  <= 1'b1;
        end
      end
    end
  end

  assign busy_o        = (r_state == S_CALC);
  assign ready_o       = r_ready;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;

endmodule
